// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle control FSM for a 32-bit processor. It owns the program counter
// and walks each instruction through FETCH -> DECODE -> EXECUTE -> [MEM] -> WB.
// Every phase change is an explicit state transition on clk; there is no
// derived or divided clock anywhere in the sequencer.
//
// The memory handshakes are request/ack. A request that waits MEM_TIMEOUT
// cycles without an ack puts the sequencer into the terminal FAULT state.
//
// Ports:
//   clk        system clock; all state changes on its rising edge
//   start      asynchronous active-high reset
//   halt       stop after the current instruction (sampled only in WB)
//   imem_ack   instruction memory ack; the instruction word is valid this cycle
//   imem_req   instruction fetch request; the address is pc
//   ir_load    one-cycle pulse: capture the instruction word into IR
//   is_mem     decoded flag: the instruction uses data memory (sampled in EXECUTE)
//   br_taken   branch/jump taken (sampled in EXECUTE)
//   br_target  branch/jump target (sampled in EXECUTE; low two bits dropped)
//   dmem_req   data memory request
//   dmem_ack   data memory ack
//   reg_we     one-cycle register-file write enable pulse
//   pc         current program counter
//   state      FSM state code
//   instr_cnt  retired instruction count (wraps)
//   fault      sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              start,
  input  logic              halt,
  input  logic              imem_ack,
  output logic              imem_req,
  output logic              ir_load,
  input  logic              is_mem,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic              dmem_req,
  input  logic              dmem_ack,
  output logic              reg_we,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        state,
  output logic [31:0]       instr_cnt,
  output logic              fault
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALTED  = 3'd5,
    S_FAULT   = 3'd6
  } state_e;

  localparam int unsigned       CNT_W       = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
  // Clearing the two low bits keeps branch targets word aligned while still
  // consuming every bit of br_target.
  localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  wait_inc;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic [31:0]       instr_cnt_q, instr_cnt_d;
  logic              fault_q, fault_d;

  assign wait_inc = wait_cnt_q + CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State register (with the request wait counter)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values that were current before the edge, whatever the statement order.
  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves a
  // signal unassigned would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          state_d    = S_DECODE;
          wait_cnt_d = '0;
        end else if (wait_inc == TIMEOUT_CNT) begin
          state_d    = S_FAULT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: state_d = is_mem ? S_MEM : S_WB;
      // Only dmem_ack counts here; a stray imem_ack is ignored.
      S_MEM: begin
        if (dmem_ack) begin
          state_d    = S_WB;
          wait_cnt_d = '0;
        end else if (wait_inc == TIMEOUT_CNT) begin
          state_d    = S_FAULT;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      S_WB:      state_d = halt ? S_HALTED : S_FETCH;
      S_HALTED:  state_d = S_HALTED;
      S_FAULT:   state_d = S_FAULT;
      // Code 7 cannot be reached by design; treat it as a fault if it is.
      default:   state_d = S_FAULT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers: pc, the pending next pc, the retire count, fault flag
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    next_pc_d   = next_pc_q;
    instr_cnt_d = instr_cnt_q;
    fault_d     = fault_q | (state_d == S_FAULT);

    // The successor address is latched in EXECUTE but committed only in WB,
    // so pc stays stable for the whole instruction.
    if (state_q == S_EXECUTE) begin
      next_pc_d = br_taken ? (br_target & ALIGN_MASK) : (pc_q + PC_STEP);
    end
    if (state_q == S_WB) begin
      pc_d        = next_pc_q;
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      pc_q        <= RESET_VEC;
      next_pc_q   <= RESET_VEC;
      instr_cnt_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      next_pc_q   <= next_pc_d;
      instr_cnt_q <= instr_cnt_d;
      fault_q     <= fault_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (Moore, except ir_load which also needs the ack)
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    reg_we   = 1'b0;
    case (state_q)
      // Held off while reset is asserted; follows the state once released.
      S_FETCH: imem_req = ~start;
      S_MEM:   dmem_req = 1'b1;
      S_WB:    reg_we   = 1'b1;
      default: ;
    endcase
    ir_load = imem_req & imem_ack;
  end

  assign pc        = pc_q;
  assign state     = state_q;
  assign instr_cnt = instr_cnt_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Self-checking bench for pc_sequencer (ADDR_W=32, RESET_VEC=0, MEM_TIMEOUT=15).
// A cycle table covers straight-line, branch and delayed-ack memory
// instructions. Hand-written sequences cover timeouts, halt, reset in the
// middle of a request and pc wrap. A randomized run plans each instruction as
// a list of phases (fetch waits, optional memory waits). It then predicts pc
// and the retire count from the architectural rules.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        start;
  logic        halt;
  logic        imem_ack;
  logic        imem_req;
  logic        ir_load;
  logic        is_mem;
  logic        br_taken;
  logic [31:0] br_target;
  logic        dmem_req;
  logic        dmem_ack;
  logic        reg_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic [31:0] instr_cnt;
  logic        fault;

  int n_pass  = 0;
  int n_total = 0;

  // Architectural model: pc and retired count, advanced once per instruction.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  pc_sequencer #(
    .ADDR_W      (32),
    .RESET_VEC   (32'h0000_0000),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .start     (start),
    .halt      (halt),
    .imem_ack  (imem_ack),
    .imem_req  (imem_req),
    .ir_load   (ir_load),
    .is_mem    (is_mem),
    .br_taken  (br_taken),
    .br_target (br_target),
    .dmem_req  (dmem_req),
    .dmem_ack  (dmem_ack),
    .reg_we    (reg_we),
    .pc        (pc),
    .state     (state),
    .instr_cnt (instr_cnt),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    halt      = 1'b0;
    imem_ack  = 1'b0;
    dmem_ack  = 1'b0;
    is_mem    = 1'b0;
    br_taken  = 1'b0;
    br_target = 32'h0;
  endtask

  // Leaves the bench 1 unit after a rising edge with reset just released.
  task automatic do_reset();
    clear_inputs();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    m_pc  = 32'h0;
    m_cnt = 32'h0;
  endtask

  // Compare one cycle's outputs against the expected phase and the model.
  task automatic exp_cycle(input string tag, input logic [2:0] st, input logic ireq,
                           input logic dreq, input logic we, input logic irl);
    check({tag, ".state"},     {29'h0, state},  {29'h0, st});
    check({tag, ".imem_req"},  {31'h0, imem_req}, {31'h0, ireq});
    check({tag, ".dmem_req"},  {31'h0, dmem_req}, {31'h0, dreq});
    check({tag, ".reg_we"},    {31'h0, reg_we},   {31'h0, we});
    check({tag, ".ir_load"},   {31'h0, ir_load},  {31'h0, irl});
    check({tag, ".pc"},        pc,        m_pc);
    check({tag, ".instr_cnt"}, instr_cnt, m_cnt);
    check({tag, ".fault"},     {31'h0, fault},    32'h0);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Run one instruction through the DUT: fw fetch wait cycles, then the
  // decode/execute phases, mw data wait cycles if im, then write-back with
  // halt = hl. Inputs that matter only in other phases are driven with noise.
  task automatic exec_instr(input int fw, input logic im, input int mw,
                            input logic bt, input logic [31:0] tgt, input logic hl);
    for (int k = 0; k <= fw; k++) begin
      imem_ack = (k == fw); dmem_ack = rbit(); halt = rbit();
      is_mem = rbit(); br_taken = rbit(); br_target = $urandom;
      #1; exp_cycle($sformatf("fetch%0d", k), 3'd0, 1'b1, 1'b0, 1'b0, imem_ack);
      tick();
    end
    imem_ack = rbit(); dmem_ack = rbit(); halt = hl ? 1'b1 : rbit();
    is_mem = rbit(); br_taken = rbit(); br_target = $urandom;
    #1; exp_cycle("decode", 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    imem_ack = rbit(); dmem_ack = rbit(); halt = hl ? 1'b1 : rbit();
    is_mem = im; br_taken = bt; br_target = tgt;
    #1; exp_cycle("execute", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    if (im) begin
      for (int k = 0; k <= mw; k++) begin
        dmem_ack = (k == mw); imem_ack = rbit(); halt = rbit();
        is_mem = rbit(); br_taken = rbit(); br_target = $urandom;
        #1; exp_cycle($sformatf("mem%0d", k), 3'd3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
      end
    end
    imem_ack = rbit(); dmem_ack = rbit(); halt = hl;
    is_mem = rbit(); br_taken = rbit(); br_target = $urandom;
    #1; exp_cycle("wb", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    m_pc  = bt ? {tgt[31:2], 2'b00} : m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    clear_inputs();
  endtask

  // ---------------------------------------------------------------------------
  // Cycle table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        ia, da, im, bt;
    logic [31:0] tgt;
    logic        hl;
    logic [2:0]  st;
    logic [31:0] pc;
    logic        ireq, dreq, we, irl;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ia, input logic da, input logic im, input logic bt,
                     input logic [31:0] tgt, input logic hl, input logic [2:0] st,
                     input logic [31:0] epc, input logic ireq, input logic dreq,
                     input logic we, input logic irl, input logic [31:0] cnt);
    vec_t v;
    v.ia = ia; v.da = da; v.im = im; v.bt = bt; v.tgt = tgt; v.hl = hl;
    v.st = st; v.pc = epc; v.ireq = ireq; v.dreq = dreq; v.we = we;
    v.irl = irl; v.cnt = cnt;
    vq.push_back(v);
  endtask

  initial begin
    logic [31:0] saved_pc;
    start = 1'b0;
    clear_inputs();

    //   ia da im bt tgt          hl  st  pc           ireq dreq we irl cnt
    // pc 0: straight line, stray dmem_ack in FETCH and imem_ack in DECODE.
    add(1, 1, 0, 0, 32'h0,       0,  0,  32'h000,     1,   0,   0, 1,  0);
    add(1, 0, 0, 0, 32'h0,       0,  1,  32'h000,     0,   0,   0, 0,  0);
    add(1, 0, 0, 0, 32'h0,       0,  2,  32'h000,     0,   0,   0, 0,  0);
    add(1, 0, 0, 0, 32'h0,       0,  4,  32'h000,     0,   0,   1, 0,  0);
    // pc 4
    add(1, 0, 0, 0, 32'h0,       0,  0,  32'h004,     1,   0,   0, 1,  1);
    add(1, 0, 0, 0, 32'h0,       0,  1,  32'h004,     0,   0,   0, 0,  1);
    add(1, 0, 0, 0, 32'h0,       0,  2,  32'h004,     0,   0,   0, 0,  1);
    add(1, 0, 0, 0, 32'h0,       0,  4,  32'h004,     0,   0,   1, 0,  1);
    // pc 8
    add(1, 0, 0, 0, 32'h0,       0,  0,  32'h008,     1,   0,   0, 1,  2);
    add(1, 0, 0, 0, 32'h0,       0,  1,  32'h008,     0,   0,   0, 0,  2);
    add(1, 0, 0, 0, 32'h0,       0,  2,  32'h008,     0,   0,   0, 0,  2);
    add(1, 0, 0, 0, 32'h0,       0,  4,  32'h008,     0,   0,   1, 0,  2);
    // pc 12: is_mem noise in DECODE, branch to 0x103 in EXECUTE
    add(1, 0, 0, 0, 32'h0,       0,  0,  32'h00C,     1,   0,   0, 1,  3);
    add(1, 0, 1, 0, 32'h0,       0,  1,  32'h00C,     0,   0,   0, 0,  3);
    add(1, 0, 0, 1, 32'h103,     0,  2,  32'h00C,     0,   0,   0, 0,  3);
    add(1, 0, 0, 0, 32'h0,       0,  4,  32'h00C,     0,   0,   1, 0,  3);
    // pc 0x100: memory instruction, dmem_ack delayed 3 cycles
    add(1, 0, 0, 0, 32'h0,       0,  0,  32'h100,     1,   0,   0, 1,  4);
    add(1, 0, 0, 0, 32'h0,       0,  1,  32'h100,     0,   0,   0, 0,  4);
    add(1, 0, 1, 0, 32'h0,       0,  2,  32'h100,     0,   0,   0, 0,  4);
    add(1, 0, 0, 0, 32'h0,       0,  3,  32'h100,     0,   1,   0, 0,  4);
    add(0, 0, 0, 0, 32'h0,       0,  3,  32'h100,     0,   1,   0, 0,  4);
    add(0, 0, 0, 0, 32'h0,       0,  3,  32'h100,     0,   1,   0, 0,  4);
    add(0, 1, 0, 0, 32'h0,       0,  3,  32'h100,     0,   1,   0, 0,  4);
    add(1, 0, 0, 0, 32'h0,       0,  4,  32'h100,     0,   0,   1, 0,  4);
    add(1, 0, 0, 0, 32'h0,       0,  0,  32'h104,     1,   0,   0, 1,  5);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      imem_ack = vq[i].ia; dmem_ack = vq[i].da; is_mem = vq[i].im;
      br_taken = vq[i].bt; br_target = vq[i].tgt; halt = vq[i].hl;
      #1;
      check($sformatf("vec%0d.state", i),     {29'h0, state},    {29'h0, vq[i].st});
      check($sformatf("vec%0d.pc", i),        pc,                vq[i].pc);
      check($sformatf("vec%0d.imem_req", i),  {31'h0, imem_req}, {31'h0, vq[i].ireq});
      check($sformatf("vec%0d.dmem_req", i),  {31'h0, dmem_req}, {31'h0, vq[i].dreq});
      check($sformatf("vec%0d.reg_we", i),    {31'h0, reg_we},   {31'h0, vq[i].we});
      check($sformatf("vec%0d.ir_load", i),   {31'h0, ir_load},  {31'h0, vq[i].irl});
      check($sformatf("vec%0d.instr_cnt", i), instr_cnt,         vq[i].cnt);
      tick();
    end

    // --- Fetch timeout: imem_ack held low for 15 cycles ---------------------
    do_reset();
    for (int k = 0; k < 14; k++) tick();
    #1;
    check("ftmo.state_at_14", {29'h0, state}, 32'd0);
    check("ftmo.fault_at_14", {31'h0, fault}, 32'd0);
    tick();
    imem_ack = 1'b1;
    #1;
    check("ftmo.state",    {29'h0, state},    32'd6);
    check("ftmo.fault",    {31'h0, fault},    32'd1);
    check("ftmo.imem_req", {31'h0, imem_req}, 32'd0);
    check("ftmo.ir_load",  {31'h0, ir_load},  32'd0);
    check("ftmo.pc",       pc,                32'h0);
    tick(); tick();
    #1;
    check("ftmo.state_hold", {29'h0, state}, 32'd6);
    check("ftmo.fault_hold", {31'h0, fault}, 32'd1);

    // --- Halt: asserted from DECODE through WB ------------------------------
    do_reset();
    exec_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b1);
    imem_ack = 1'b1;
    #1;
    check("halt.state",     {29'h0, state},    32'd5);
    check("halt.pc",        pc,                32'h4);
    check("halt.instr_cnt", instr_cnt,         32'd1);
    check("halt.imem_req",  {31'h0, imem_req}, 32'd0);
    tick(); tick(); tick();
    #1;
    check("halt.state_hold", {29'h0, state},    32'd5);
    check("halt.imem_hold",  {31'h0, imem_req}, 32'd0);
    check("halt.reg_we",     {31'h0, reg_we},   32'd0);
    start = 1'b1;
    #2;
    check("halt.rst_state", {29'h0, state}, 32'd0);
    check("halt.rst_pc",    pc,             32'h0);
    check("halt.rst_cnt",   instr_cnt,      32'd0);
    tick();
    start = 1'b0;
    #1;
    check("halt.rel_imem_req", {31'h0, imem_req}, 32'd1);

    // --- Wrap at the top of the address space, then reset mid-MEM -----------
    do_reset();
    exec_instr(0, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    #1;
    check("wrap.pc_top", pc, 32'hFFFF_FFFC);
    exec_instr(1, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    #1;
    check("wrap.pc_zero", pc, 32'h0);
    exec_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b0);
    imem_ack = 1'b1; tick();
    imem_ack = 1'b0; tick();
    is_mem = 1'b1;   tick();
    is_mem = 1'b0;
    #1;
    check("rstmem.state",    {29'h0, state},    32'd3);
    check("rstmem.dmem_req", {31'h0, dmem_req}, 32'd1);
    check("rstmem.pc",       pc,                32'h4);
    #2;
    start = 1'b1;
    #1;
    check("rstmem.dmem_drop", {31'h0, dmem_req}, 32'd0);
    check("rstmem.state0",    {29'h0, state},    32'd0);
    check("rstmem.pc0",       pc,                32'h0);
    check("rstmem.cnt0",      instr_cnt,         32'd0);
    tick();
    start = 1'b0;
    #1;
    check("rstmem.fetch_req", {31'h0, imem_req}, 32'd1);
    check("rstmem.fetch_pc",  pc,                32'h0);

    // --- Data memory timeout ------------------------------------------------
    do_reset();
    imem_ack = 1'b1; tick();
    imem_ack = 1'b0; tick();
    is_mem = 1'b1;   tick();
    is_mem = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    #1;
    check("dtmo.state_at_14", {29'h0, state},    32'd3);
    check("dtmo.dmem_at_14",  {31'h0, dmem_req}, 32'd1);
    tick();
    dmem_ack = 1'b1;
    #1;
    check("dtmo.state",    {29'h0, state},    32'd6);
    check("dtmo.fault",    {31'h0, fault},    32'd1);
    check("dtmo.dmem_req", {31'h0, dmem_req}, 32'd0);
    check("dtmo.imem_req", {31'h0, imem_req}, 32'd0);
    check("dtmo.pc",       pc,                32'h0);

    // --- Longest legal waits (one short of the timeout) ---------------------
    do_reset();
    exec_instr(14, 1'b1, 14, 1'b0, 32'h0, 1'b0);
    exec_instr(0, 1'b0, 0, 1'b0, 32'h0, 1'b0);

    // --- Randomized instruction stream --------------------------------------
    do_reset();
    for (int n = 0; n < 60; n++) begin
      exec_instr(int'($urandom_range(0, 4)), rbit(), int'($urandom_range(0, 4)),
                 ($urandom_range(0, 3) == 0), $urandom, 1'b0);
    end
    saved_pc = m_pc;
    exec_instr(int'($urandom_range(0, 3)), 1'b1, int'($urandom_range(0, 3)),
               1'b0, 32'h0, 1'b1);
    #1;
    check("rand.halted_state", {29'h0, state},    32'd5);
    check("rand.halted_pc",    pc,                saved_pc + 32'd4);
    check("rand.halted_cnt",   instr_cnt,         32'd61);
    check("rand.halted_req",   {31'h0, imem_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit processor's program counter and instruction phases.
- Owns the PC register and sequences FETCH, DECODE, EXECUTE, optional MEM, and WRITEBACK.
- Handshakes with instruction and data memory.
- Replaces free-running clock division: every phase advance is an explicit state transition on clk.

Parameters:
ADDR_W, 32, PC/address width
RESET_VEC, 32'h0000_0000, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles a memory request may wait for ack before fault (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
start  input  1  asynchronous active-high reset
halt  input  1  stop after the current instruction completes
imem_ack  input  1  instruction memory ack; instruction word valid this cycle
imem_req  output  1  instruction fetch request, address = pc
ir_load  output  1  one-cycle pulse: capture instruction word into IR
is_mem  input  1  decoded flag: instruction accesses data memory (sampled in EXECUTE)
br_taken  input  1  branch/jump taken (sampled in EXECUTE)
br_target  input  ADDR_W  branch/jump target (sampled in EXECUTE)
dmem_req  output  1  data memory request
dmem_ack  input  1  data memory ack
reg_we  output  1  one-cycle register-file write enable pulse
pc  output  ADDR_W  current program counter
state  output  3  FSM state code
instr_cnt  output  32  retired instruction count
fault  output  1  sticky memory-timeout flag

Behaviour:
- Reset (start=1, asynchronous, any cycle including mid-request):
  - state=FETCH, pc=RESET_VEC, next_pc=RESET_VEC, instr_cnt=0, fault=0, wait counter=0.
  - All outputs deasserted except imem_req, which follows state after reset release.
- State codes: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALTED=5, FAULT=6. Code 7 is unreachable; if reached, go to FAULT.
- Decoded outputs (Moore, combinational from state; ir_load is the exception):
  - imem_req=1 in FETCH only.
  - dmem_req=1 in MEM only.
  - reg_we=1 in WB only.
  - ir_load=imem_req & imem_ack.
- FETCH:
  - Wait counter increments each cycle without ack.
  - imem_ack=1: ir_load pulse, counter cleared, go to DECODE.
  - Counter reaches MEM_TIMEOUT without ack: go to FAULT.
- DECODE: exactly 1 cycle, go to EXECUTE.
- EXECUTE (exactly 1 cycle):
  - next_pc = br_taken ? {br_target[ADDR_W-1:2],2'b00} : pc+4, modulo 2^ADDR_W (0xFFFF_FFFC+4 wraps to 0).
  - Go to MEM if is_mem=1, else go to WB.
- MEM: same ack/timeout rules as FETCH using dmem_ack; on ack go to WB.
- WB (1 cycle):
  - reg_we=1, pc<=next_pc, instr_cnt<=instr_cnt+1 (wraps).
  - halt=1 at this edge: go to HALTED; otherwise go to FETCH.
- halt is sampled only in WB. Assertion in any other state takes effect at the next WB.
- HALTED and FAULT are terminal until reset. In FAULT, fault=1 and no requests are issued; pc holds.
- Acks arriving when the matching req=0 are ignored. imem_ack and dmem_ack both high: only the one matching the current state counts.
- Latency:
  - Non-memory instruction with 0-wait ack: 4 cycles (F,D,E,WB).
  - Memory instruction: 5 cycles plus wait cycles.
- pc changes only on the WB edge or on reset.

Test Plan:
- Reset release, imem_ack tied 1, is_mem=0, br_taken=0 -> pc goes 0,4,8,12 at each WB; instr_cnt=3 after 12 cycles; reg_we pulses every 4th cycle.
- EXECUTE with br_taken=1, br_target=0x0000_0103 -> pc=0x0000_0100 after WB.
- is_mem=1, dmem_ack delayed 3 cycles -> MEM held 4 cycles with dmem_req=1; instruction completes in 8 cycles; single reg_we pulse.
- imem_ack held 0 with MEM_TIMEOUT=15 -> state=6 and fault=1 after 15 cycles; imem_req=0 afterwards; pc unchanged.
- halt asserted during DECODE and held through WB -> state=5 after WB; pc=next_pc; no further imem_req. Then start pulse -> state=0, pc=0, instr_cnt=0.
- start asserted mid-MEM with dmem_req=1 -> dmem_req drops immediately (asynchronous); FETCH at RESET_VEC after release. pc at 0xFFFF_FFFC non-branch -> wraps to 0.
